// File: rtl/reg_out_bank.sv
// rtl/reg_out_bank.sv - double-buffered multi-channel output register bank
// Each channel is LATCH or PULSE; a common commit moves all shadows to the outputs.
module reg_out_bank #(
  parameter int             W          = 2,
  parameter int             CH         = 4,
  parameter int             PULSE_LEN  = 8,
  parameter int             CNT_W      = 4,
  parameter logic [CH-1:0]  PULSE_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   log_in,
  input  logic [CH-1:0]     en,
  input  logic              commit,
  input  logic              clr,
  output logic [CH*W-1:0]   out,
  output logic [CH-1:0]     changed,
  output logic [CH-1:0]     busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

  logic [W-1:0]     shadow_q [CH];
  logic [W-1:0]     shadow_d [CH];
  logic [W-1:0]     out_q    [CH];
  logic [W-1:0]     out_d    [CH];
  logic [CNT_W-1:0] cnt_q    [CH];
  logic [CNT_W-1:0] cnt_d    [CH];
  state_t           st_q     [CH];
  state_t           st_d     [CH];
  logic [CH-1:0]    changed_q;
  logic [CH-1:0]    changed_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        shadow_q[c] <= '0;
        out_q[c]    <= '0;
        cnt_q[c]    <= '0;
        st_q[c]     <= IDLE;
      end
      changed_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        shadow_q[c] <= shadow_d[c];
        out_q[c]    <= out_d[c];
        cnt_q[c]    <= cnt_d[c];
        st_q[c]     <= st_d[c];
      end
      changed_q <= changed_d;
    end
  end

  always_comb begin
    changed_d = '0;
    for (int c = 0; c < CH; c++) begin
      shadow_d[c] = en[c] ? log_in[c*W +: W] : shadow_q[c];
      out_d[c]    = out_q[c];
      cnt_d[c]    = cnt_q[c];
      st_d[c]     = st_q[c];

      if (PULSE_MASK[c]) begin
        case (st_q[c])
          IDLE: begin
            if (commit && shadow_q[c] != '0) begin
              out_d[c] = shadow_q[c];
              cnt_d[c] = RELOAD;
              st_d[c]  = ACTIVE;
            end
          end
          ACTIVE: begin
            if (commit) begin
              if (shadow_q[c] != '0) begin
                out_d[c] = shadow_q[c];
                cnt_d[c] = RELOAD;
              end else begin
                out_d[c] = '0;
                cnt_d[c] = '0;
                st_d[c]  = IDLE;
              end
            end else if (cnt_q[c] == '0) begin
              out_d[c] = '0;
              st_d[c]  = IDLE;
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
          end
          default: st_d[c] = IDLE;
        endcase
      end else if (commit) begin
        // Shadow value from before this edge; a same-edge en lands in the shadow only.
        out_d[c] = shadow_q[c];
      end

      if (clr) begin
        shadow_d[c] = '0;
        out_d[c]    = '0;
        cnt_d[c]    = '0;
        st_d[c]     = IDLE;
      end

      changed_d[c] = (out_d[c] != out_q[c]);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_pack
    assign out[c*W +: W] = out_q[c];
    assign busy[c]       = (st_q[c] == ACTIVE);
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_reg_out_bank.sv
// tb/tb_reg_out_bank.sv - scoreboard bench for reg_out_bank
// Driver pushes hand-computed expectations; a monitor pops and checks after each edge.
module tb_reg_out_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] log_in;
  logic [3:0] en;
  logic       commit;
  logic       clr;
  logic [7:0] out;
  logic [3:0] changed;
  logic [3:0] busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] o;
    logic [3:0] c;
    logic [3:0] b;
    string      n;
  } exp_t;

  exp_t sb [$];

  reg_out_bank #(
    .W(2), .CH(4), .PULSE_LEN(8), .CNT_W(4), .PULSE_MASK(4'b0010)
  ) dut (
    .clk(clk), .rst(rst), .log_in(log_in), .en(en), .commit(commit), .clr(clr),
    .out(out), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Drive inputs for the coming edge and queue the outputs expected after it.
  task automatic step(input logic [7:0] l, input logic [3:0] e, input logic cm,
                      input logic cl, input logic [7:0] eo, input logic [3:0] ec,
                      input logic [3:0] eb, input string n);
    exp_t x;
    @(negedge clk);
    log_in = l; en = e; commit = cm; clr = cl;
    x.o = eo; x.c = ec; x.b = eb; x.n = n;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk({x.n, ".out"},     out,            x.o);
        chk({x.n, ".changed"}, {4'h0, changed}, {4'h0, x.c});
        chk({x.n, ".busy"},    {4'h0, busy},    {4'h0, x.b});
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    rst = 1'b0; log_in = '0; en = '0; commit = 1'b0; clr = 1'b0;
    #3;
    chk("reset.out", out, 8'h00);
    chk("reset.changed", {4'h0, changed}, 8'h00);
    chk("reset.busy", {4'h0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // T1: ch0 latched at 11, ch1 pulsing, then asynchronous reset mid-pulse
    step(8'h0F, 4'b0011, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, "t1_load");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h0F, 4'b0011, 4'b0010, "t1_commit");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b0010, "t1_hold");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_async.out", out, 8'h00);
    chk("t1_async.changed", {4'h0, changed}, 8'h00);
    chk("t1_async.busy", {4'h0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    // shadows were cleared, so a bare commit must leave everything at zero
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, "t1_post");

    // T2: latch ch0 = 10, held for 50 cycles
    step(8'h02, 4'b0001, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, "t2_en");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h02, 4'b0001, 4'b0000, "t2_commit");
    for (int i = 0; i < 50; i++)
      step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0000, 4'b0000, "t2_hold");

    // T3: same-edge en and commit
    step(8'h01, 4'b0001, 1'b0, 1'b0, 8'h02, 4'b0000, 4'b0000, "t3_en01");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h01, 4'b0001, 4'b0000, "t3_c01");
    step(8'h03, 4'b0001, 1'b1, 1'b0, 8'h01, 4'b0000, 4'b0000, "t3_same");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h03, 4'b0001, 4'b0000, "t3_c11");

    // T4: ch1 pulse of exactly 8 cycles
    step(8'h0C, 4'b0010, 1'b0, 1'b0, 8'h03, 4'b0000, 4'b0000, "t4_en");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h0F, 4'b0010, 4'b0010, "t4_rise");
    for (int i = 0; i < 7; i++)
      step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b0010, "t4_active");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0010, 4'b0000, "t4_fall");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 4'b0000, "t4_idle");

    // T5: retrigger with 10 so that 10 first appears in the 5th active cycle
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h0F, 4'b0010, 4'b0010, "t5_rise");
    step(8'h08, 4'b0010, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b0010, "t5_en10");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b0010, "t5_a3");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0F, 4'b0000, 4'b0010, "t5_a4");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h0B, 4'b0010, 4'b0010, "t5_retrig");
    for (int i = 0; i < 7; i++)
      step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0B, 4'b0000, 4'b0010, "t5_active");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0010, 4'b0000, "t5_fall");

    // T6: clr beats commit and en
    step(8'h02, 4'b0001, 1'b0, 1'b0, 8'h03, 4'b0000, 4'b0000, "t6_en");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h0A, 4'b0011, 4'b0010, "t6_commit");
    step(8'h00, 4'b0000, 1'b0, 1'b0, 8'h0A, 4'b0000, 4'b0010, "t6_active");
    step(8'hFF, 4'b1111, 1'b1, 1'b1, 8'h00, 4'b0011, 4'b0000, "t6_clr");
    step(8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, "t6_after");

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
